uart_apb_echo: RTL and testbench

UART_APB_ECHO -- requirements
Module: uart_apb_echo

---
 rtl/uart_apb_pkg.sv | 34 +++
 rtl/apb_xfer.sv | 96 +++++++++
 rtl/uart_apb_echo.sv | 141 ++++++++++++++
 tb/tb_uart_apb_echo.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART echo block: register map, STATUS bits
// and the state encodings of the sequencer and the APB transfer engine.
package uart_apb_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_CTRL1  = 8'h08;
    localparam logic [7:0] OFF_CTRL2  = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    localparam int STATUS_TXRDY = 0;
    localparam int STATUS_RXRDY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CTRL1,
        ST_WR_CTRL2,
        ST_POLL_RX,
        ST_RD_RX,
        ST_POLL_TX,
        ST_WR_TX
    } echo_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SETUP,
        XF_ACCESS
    } xfer_state_e;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] off);
        return base + {24'h0, off};
    endfunction

endpackage

// File: rtl/apb_xfer.sv
// Single APB master transfer engine: SETUP, ACCESS until PREADY, then one idle
// cycle before the next request is accepted. Bus outputs are registered.
module apb_xfer
    import uart_apb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [7:0]  wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output xfer_state_e dbg_state_o
);

    xfer_state_e state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= XF_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
        end
    end

    // Address/direction/data are captured only when a request is accepted,
    // so they stay frozen for the whole SETUP/ACCESS window.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        done_o    = 1'b0;
        case (state_q)
            XF_IDLE: begin
                if (req_i) begin
                    state_d  = XF_SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = addr_i;
                    pwrite_d = write_i;
                    pwdata_d = write_i ? {24'h0, wdata_i} : 32'h0;
                end
            end
            XF_SETUP: begin
                state_d   = XF_ACCESS;
                penable_d = 1'b1;
            end
            XF_ACCESS: begin
                if (pready_i) begin
                    done_o    = 1'b1;
                    state_d   = XF_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: state_d = XF_IDLE;
        endcase
    end

    assign rdata_o     = prdata_i;
    assign err_o       = done_o & pslverr_i;
    assign paddr_o     = paddr_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: rtl/uart_apb_echo.sv
// Configures a fabric UART over APB, then echoes every received byte back out,
// counting echoes and flagging any slave error.
module uart_apb_echo
    import uart_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [12:0] BAUD_VAL   = 13'd162,
    parameter logic [2:0]  CTRL2_MODE = 3'b001
) (
    input  logic        FIC_0_CLK,
    input  logic        FAB_RESET,
    input  logic        START,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        CFG_DONE,
    output logic [15:0] ECHO_CNT,
    output logic        ERR,
    output echo_state_e dbg_state_o
);

    echo_state_e state_q, state_d;
    logic        cfg_done_q, cfg_done_d;
    logic [15:0] echo_cnt_q, echo_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;

    logic        x_req;
    logic        x_write;
    logic [7:0]  x_off;
    logic [7:0]  x_wdata;
    logic        x_done;
    logic        x_err;
    logic [31:0] x_rdata;
    xfer_state_e x_state;

    always_ff @(posedge FIC_0_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            state_q    <= ST_IDLE;
            cfg_done_q <= 1'b0;
            echo_cnt_q <= '0;
            byte_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            echo_cnt_q <= echo_cnt_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
        end
    end

    // A STATUS read that completes with an error never counts as ready.
    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        echo_cnt_d = echo_cnt_q;
        byte_d     = byte_q;
        err_d      = err_q | x_err;
        x_req      = 1'b1;
        x_write    = 1'b0;
        x_off      = OFF_STATUS;
        x_wdata    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                x_req = 1'b0;
                if (START) state_d = ST_WR_CTRL1;
            end
            ST_WR_CTRL1: begin
                x_write = 1'b1;
                x_off   = OFF_CTRL1;
                x_wdata = BAUD_VAL[7:0];
                if (x_done) state_d = ST_WR_CTRL2;
            end
            ST_WR_CTRL2: begin
                x_write = 1'b1;
                x_off   = OFF_CTRL2;
                x_wdata = {BAUD_VAL[12:8], CTRL2_MODE};
                if (x_done) begin
                    cfg_done_d = 1'b1;
                    state_d    = ST_POLL_RX;
                end
            end
            ST_POLL_RX: begin
                if (x_done && !x_err && x_rdata[STATUS_RXRDY]) state_d = ST_RD_RX;
            end
            ST_RD_RX: begin
                x_off = OFF_RXDATA;
                if (x_done) begin
                    byte_d  = x_rdata[7:0];
                    state_d = ST_POLL_TX;
                end
            end
            ST_POLL_TX: begin
                if (x_done && !x_err && x_rdata[STATUS_TXRDY]) state_d = ST_WR_TX;
            end
            ST_WR_TX: begin
                x_write = 1'b1;
                x_off   = OFF_TXDATA;
                x_wdata = byte_q;
                if (x_done) begin
                    echo_cnt_d = echo_cnt_q + 16'd1;
                    state_d    = ST_POLL_RX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    apb_xfer u_xfer (
        .clk_i       (FIC_0_CLK),
        .rst_i       (FAB_RESET),
        .req_i       (x_req),
        .addr_i      (reg_addr(BASE_ADDR, x_off)),
        .write_i     (x_write),
        .wdata_i     (x_wdata),
        .done_o      (x_done),
        .rdata_o     (x_rdata),
        .err_o       (x_err),
        .paddr_o     (PADDR),
        .psel_o      (PSEL),
        .penable_o   (PENABLE),
        .pwrite_o    (PWRITE),
        .pwdata_o    (PWDATA),
        .prdata_i    (PRDATA),
        .pready_i    (PREADY),
        .pslverr_i   (PSLVERR),
        .dbg_state_o (x_state)
    );

    assign CFG_DONE    = cfg_done_q;
    assign ECHO_CNT    = echo_cnt_q;
    assign ERR         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_apb_echo.sv
// Bench for uart_apb_echo: a scripted APB slave feeds STATUS/RXDATA responses
// and the expected transfer stream is derived from the echo rules.
module tb_uart_apb_echo;

    localparam logic [31:0] A_TX     = 32'h0000_0000;
    localparam logic [31:0] A_RX     = 32'h0000_0004;
    localparam logic [31:0] A_CTRL1  = 32'h0000_0008;
    localparam logic [31:0] A_CTRL2  = 32'h0000_000C;
    localparam logic [31:0] A_STATUS = 32'h0000_0010;
    localparam logic [12:0] BAUD     = 13'd162;
    localparam logic [2:0]  MODE     = 3'b001;
    localparam int          W        = 65;

    logic        FIC_0_CLK = 1'b0;
    logic        FAB_RESET = 1'b1;
    logic        START     = 1'b0;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA  = 32'h0;
    logic        PREADY  = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        CFG_DONE;
    logic [15:0] ECHO_CNT;
    logic        ERR;
    logic [2:0]  dbg_state;

    uart_apb_echo dut (
        .FIC_0_CLK   (FIC_0_CLK),
        .FAB_RESET   (FAB_RESET),
        .START       (START),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .CFG_DONE    (CFG_DONE),
        .ECHO_CNT    (ECHO_CNT),
        .ERR         (ERR),
        .dbg_state_o (dbg_state)
    );

    always #5 FIC_0_CLK = ~FIC_0_CLK;

    // Scripted slave responses {pslverr, prdata} and the observed/expected streams
    logic [32:0]  stat_q[$];
    logic [32:0]  rx_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] log_q[$];
    logic [15:0]  exp_cnt = 16'h0;
    int           max_wait = 0;
    int           stall_next = -1;
    logic [31:0]  stall_addr = 32'h0;
    int           wait_left = 0;
    logic         resp_scripted = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           proto_err = 0;
    int           n_done = 0;

    // Slave: decides PREADY/PRDATA just after each rising edge
    always @(posedge FIC_0_CLK) begin
        #1;
        if (FAB_RESET) begin
            PREADY = 1'b0; PSLVERR = 1'b0; wait_left = 0; resp_scripted = 1'b0;
        end else if (PSEL && !PENABLE) begin
            PREADY = 1'b0; PSLVERR = 1'b0; resp_scripted = 1'b0;
            if (stall_next >= 0 && PADDR == stall_addr) begin
                wait_left = stall_next; stall_next = -1;
            end else begin
                wait_left = $urandom_range(0, max_wait);
            end
        end else if (PSEL && PENABLE) begin
            if (wait_left > 0) begin
                PREADY = 1'b0; wait_left--;
            end else begin
                PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = $urandom; resp_scripted = 1'b0;
                if (!PWRITE && PADDR == A_STATUS) begin
                    if (stat_q.size() > 0) begin
                        {PSLVERR, PRDATA} = stat_q.pop_front(); resp_scripted = 1'b1;
                    end else begin
                        PRDATA = $urandom & 32'hFFFF_FFFC;
                    end
                end else if (!PWRITE && PADDR == A_RX) begin
                    resp_scripted = 1'b1;
                    if (rx_q.size() > 0) {PSLVERR, PRDATA} = rx_q.pop_front();
                end
            end
        end else begin
            PREADY = 1'b0; PSLVERR = 1'b0;
        end
    end

    // Monitor: logs writes and scripted reads, tracks protocol violations
    logic        prev_done = 1'b0;
    logic        in_xfer = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic        s_write;
    always @(negedge FIC_0_CLK) begin
        if (FAB_RESET) begin
            prev_done = 1'b0; in_xfer = 1'b0;
        end else begin
            if (PENABLE && !PSEL) proto_err++;
            if (PSEL && !PENABLE) begin
                if (prev_done || in_xfer) proto_err++;
                if (!PWRITE && PWDATA != 32'h0) proto_err++;
                if (PWRITE && PWDATA[31:8] != 24'h0) proto_err++;
                in_xfer = 1'b1; s_addr = PADDR; s_write = PWRITE; s_wdata = PWDATA;
            end else if (PSEL && PENABLE) begin
                if (!in_xfer || PADDR != s_addr || PWRITE != s_write || PWDATA != s_wdata) proto_err++;
            end
            prev_done = PSEL && PENABLE && PREADY;
            if (prev_done) begin
                in_xfer = 1'b0; n_done++;
                if (PWRITE || resp_scripted) log_q.push_back({PWRITE, PADDR, PWDATA});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic script_echo(input int n_rx, input int n_tx, input logic [31:0] rx_word,
                               input logic rx_err);
        for (int i = 0; i < n_rx; i++) begin
            stat_q.push_back({1'b0, $urandom & 32'hFFFF_FFFD});
            exp_q.push_back({1'b0, A_STATUS, 32'h0});
        end
        stat_q.push_back({1'b0, $urandom | 32'h2});
        exp_q.push_back({1'b0, A_STATUS, 32'h0});
        rx_q.push_back({rx_err, rx_word});
        exp_q.push_back({1'b0, A_RX, 32'h0});
        for (int i = 0; i < n_tx; i++) begin
            stat_q.push_back({1'b0, $urandom & 32'hFFFF_FFFE});
            exp_q.push_back({1'b0, A_STATUS, 32'h0});
        end
        stat_q.push_back({1'b0, $urandom | 32'h1});
        exp_q.push_back({1'b0, A_STATUS, 32'h0});
        exp_q.push_back({1'b1, A_TX, 24'h0, rx_word[7:0]});
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic wait_log();
        for (int i = 0; i < 4000 && log_q.size() < exp_q.size(); i++) @(negedge FIC_0_CLK);
        repeat (3) @(negedge FIC_0_CLK);
    endtask

    task automatic test_reset();
        FAB_RESET = 1'b1; START = 1'b0;
        repeat (3) @(negedge FIC_0_CLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {PSEL, PENABLE, PWRITE}); else n_pass++;
        n_checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0) $display("FAIL reset_bus: got %h/%h expected 0/0", PADDR, PWDATA); else n_pass++;
        n_checks++;
        if ({CFG_DONE, ERR} !== 2'b00 || ECHO_CNT !== 16'h0) $display("FAIL reset_flags: got %b cnt %h expected 00 cnt 0", {CFG_DONE, ERR}, ECHO_CNT); else n_pass++;
        FAB_RESET = 1'b0;
        repeat (6) @(negedge FIC_0_CLK);
        n_checks++;
        if (PSEL !== 1'b0) $display("FAIL idle_no_start: PSEL got %b expected 0", PSEL); else n_pass++;
    endtask

    task automatic test_config();
        logic found;
        max_wait = 0; log_q.delete(); exp_q.delete(); exp_cnt = 16'h0;
        exp_q.push_back({1'b1, A_CTRL1, 24'h0, BAUD[7:0]});
        exp_q.push_back({1'b1, A_CTRL2, 24'h0, BAUD[12:8], MODE});
        START = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge FIC_0_CLK);
            if (PSEL && PENABLE && PREADY && PADDR == A_CTRL2) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL cfg_ctrl2_seen: got 0 expected 1"); else n_pass++;
        n_checks++;
        if (CFG_DONE !== 1'b0) $display("FAIL cfg_done_early: got %b expected 0", CFG_DONE); else n_pass++;
        @(negedge FIC_0_CLK);
        n_checks++;
        if (CFG_DONE !== 1'b1) $display("FAIL cfg_done: got %b expected 1", CFG_DONE); else n_pass++;
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL cfg_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL cfg_xfer[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_echo_basic();
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            stat_q.push_back({1'b0, 32'h0});
            exp_q.push_back({1'b0, A_STATUS, 32'h0});
        end
        stat_q.push_back({1'b0, 32'h2}); exp_q.push_back({1'b0, A_STATUS, 32'h0});
        rx_q.push_back({1'b0, 32'h5A});  exp_q.push_back({1'b0, A_RX, 32'h0});
        stat_q.push_back({1'b0, 32'h1}); exp_q.push_back({1'b0, A_STATUS, 32'h0});
        exp_q.push_back({1'b1, A_TX, 32'h5A});
        exp_cnt = exp_cnt + 16'd1;
        wait_log();
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL basic_xfer[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (ECHO_CNT !== exp_cnt) $display("FAIL basic_cnt: got %h expected %h", ECHO_CNT, exp_cnt); else n_pass++;
    endtask

    task automatic test_echo_random();
        log_q.delete(); exp_q.delete(); max_wait = 3;
        for (int e = 0; e < 6; e++) script_echo($urandom_range(0, 4), $urandom_range(0, 3), $urandom, 1'b0);
        wait_log();
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL rand_xfer[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (ECHO_CNT !== exp_cnt) $display("FAIL rand_cnt: got %h expected %h", ECHO_CNT, exp_cnt); else n_pass++;
    endtask

    task automatic test_slverr();
        log_q.delete(); exp_q.delete(); max_wait = 1;
        n_checks++;
        if (ERR !== 1'b0) $display("FAIL err_clear: got %b expected 0", ERR); else n_pass++;
        // Ready bits on an erroring STATUS read must be ignored
        stat_q.push_back({1'b1, 32'h3}); exp_q.push_back({1'b0, A_STATUS, 32'h0});
        script_echo(1, 0, $urandom, 1'b1);
        wait_log();
        n_checks++;
        if (ERR !== 1'b1) $display("FAIL err_set: got %b expected 1", ERR); else n_pass++;
        script_echo(0, 1, $urandom, 1'b0);
        wait_log();
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL err_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL err_xfer[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (ERR !== 1'b1 || ECHO_CNT !== exp_cnt) $display("FAIL err_sticky: got err %b cnt %h expected err 1 cnt %h", ERR, ECHO_CNT, exp_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        log_q.delete(); exp_q.delete();
        @(negedge FIC_0_CLK);
        force dut.echo_cnt_q = 16'hFFFF;
        @(negedge FIC_0_CLK);
        release dut.echo_cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge FIC_0_CLK);
        n_checks++;
        if (ECHO_CNT !== exp_cnt) $display("FAIL wrap_preload: got %h expected %h", ECHO_CNT, exp_cnt); else n_pass++;
        script_echo(1, 1, $urandom, 1'b0);
        wait_log();
        n_checks++;
        if (ECHO_CNT !== exp_cnt) $display("FAIL wrap_cnt: got %h expected %h", ECHO_CNT, exp_cnt); else n_pass++;
        n_checks++;
        if (log_q.size() != exp_q.size() || log_q.size() == 0 || log_q[log_q.size()-1] !== exp_q[exp_q.size()-1])
            $display("FAIL wrap_xfer: got %0d entries expected %0d", log_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic found;
        log_q.delete(); exp_q.delete(); max_wait = 0;
        stall_addr = A_TX; stall_next = 40;
        script_echo(0, 0, $urandom, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge FIC_0_CLK);
            if (PSEL && PENABLE && PWRITE && PADDR == A_TX) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL rst_tx_access_seen: got 0 expected 1"); else n_pass++;
        #2 FAB_RESET = 1'b1;
        #1;
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rst_async_bus: got %b expected 00", {PSEL, PENABLE}); else n_pass++;
        n_checks++;
        if ({CFG_DONE, ERR} !== 2'b00 || ECHO_CNT !== 16'h0) $display("FAIL rst_async_flags: got %b cnt %h expected 00 cnt 0", {CFG_DONE, ERR}, ECHO_CNT); else n_pass++;
        stat_q.delete(); rx_q.delete(); stall_next = -1; exp_cnt = 16'h0;
        repeat (2) @(negedge FIC_0_CLK);
        log_q.delete(); exp_q.delete();
        exp_q.push_back({1'b1, A_CTRL1, 24'h0, BAUD[7:0]});
        exp_q.push_back({1'b1, A_CTRL2, 24'h0, BAUD[12:8], MODE});
        FAB_RESET = 1'b0;
        wait_log();
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL rst_reconf_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL rst_reconf[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (CFG_DONE !== 1'b1 || ECHO_CNT !== exp_cnt) $display("FAIL rst_reconf_done: got %b cnt %h expected 1 cnt %h", CFG_DONE, ECHO_CNT, exp_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        logic        found, done;
        logic [31:0] sa, sd;
        logic        sw;
        int          low, unstable;
        FAB_RESET = 1'b1;
        repeat (2) @(negedge FIC_0_CLK);
        stat_q.delete(); rx_q.delete(); log_q.delete(); exp_q.delete();
        stall_addr = A_CTRL1; stall_next = 7;
        exp_q.push_back({1'b1, A_CTRL1, 24'h0, BAUD[7:0]});
        exp_q.push_back({1'b1, A_CTRL2, 24'h0, BAUD[12:8], MODE});
        FAB_RESET = 1'b0;
        found = 1'b0; sa = 32'h0; sd = 32'h0; sw = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge FIC_0_CLK);
            if (PSEL && !PENABLE && PADDR == A_CTRL1) begin
                found = 1'b1; sa = PADDR; sd = PWDATA; sw = PWRITE;
            end
        end
        low = 0; unstable = 0; done = 1'b0;
        for (int i = 0; i < 50 && found && !done; i++) begin
            @(negedge FIC_0_CLK);
            if (PADDR !== sa || PWDATA !== sd || PWRITE !== sw) unstable++;
            if (!(PSEL && PENABLE)) unstable++;
            if (PREADY) done = 1'b1; else low++;
        end
        n_checks++;
        if (!done || low != 7) $display("FAIL stall_wait: got done %b low %0d expected done 1 low 7", done, low); else n_pass++;
        n_checks++;
        if (unstable != 0) $display("FAIL stall_stable: got %0d changes expected 0", unstable); else n_pass++;
        wait_log();
        n_checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d expected %0d", log_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== exp_q[i]) $display("FAIL stall_xfer[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_err != 0) $display("FAIL apb_protocol: got %0d violations expected 0", proto_err); else n_pass++;
        n_checks++;
        if (n_done < 50) $display("FAIL apb_activity: got %0d transfers expected at least 50", n_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_config();
        test_echo_basic();
        test_echo_random();
        test_slverr();
        test_wrap();
        test_reset_mid_tx();
        test_stall();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
